// File: rtl/uart_pkg.sv
// UART receive-side shared types and constants.
// Used by uart_rx_ctrl and uart_rx_fifo.
package uart_pkg;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_14 = 2'b11
  } trig_lvl_e;

  typedef enum logic [1:0] {
    TO_IDLE,
    TO_ARMED,
    TO_TIMEOUT
  } to_state_e;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  localparam int TO_TICKS = 4;

  // Trigger entry count, clamped to the FIFO depth
  function automatic int trig_entries(
    trig_lvl_e t,
    int        depth
  );
    int n;
    n = 1;
    unique case (t)
      TRIG_1:  n = 1;
      TRIG_4:  n = 4;
      TRIG_8:  n = 8;
      TRIG_14: n = 14;
    endcase
    return (n > depth) ? depth : n;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO storage with wrapping pointers.
// Push/pop must arrive pre-qualified by the controller.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  rx_entry_t              din,
  output rx_entry_t              head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  rx_entry_t      mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;

  // Entry storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  assign head = mem[rp];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: FIFO, overrun, error count, interrupt.
// Define UART_RX_TIMEOUT_EN to build the character timeout FSM.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_push,
  input  logic [7:0]             rx_dout,
  input  logic                   rx_pe,
  input  logic                   rx_fe,
  input  logic                   rx_bi,
  input  logic                   rbr_rd,
  input  logic                   lsr_rd,
  input  logic                   fifo_en,
  input  logic                   fifo_clr,
  input  logic [1:0]             trig_lvl,
  input  logic                   char_tick,
  output logic [7:0]             rbr,
  output logic                   dr,
  output logic                   oe,
  output logic                   pe,
  output logic                   fe,
  output logic                   bi,
  output logic                   fifo_err,
  output logic                   rx_int,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          fifo_en_q;
  logic          flush;
  logic          full;
  logic          push_ok;
  logic          pop_ok;
  logic          ovr;
  logic          err_inc;
  logic          err_dec;
  logic          to_int;
  logic [LW-1:0] eff_depth;
  logic [LW-1:0] trig;
  logic [LW-1:0] err_cnt;
  logic [LW-1:0] lvl_nxt;
  rx_entry_t     din;
  rx_entry_t     head;

  assign flush     = fifo_clr | (fifo_en != fifo_en_q);
  assign eff_depth = fifo_en ? LW'(DEPTH) : LW'(1);
  assign full      = (level == eff_depth);
  assign dr        = (level != '0);
  assign pop_ok    = rbr_rd & dr & ~flush;
  assign push_ok   = rx_push & ~flush & (~full | pop_ok);
  assign ovr       = rx_push & ~flush & full & ~pop_ok;
  assign lvl_nxt   = level + LW'(push_ok) - LW'(pop_ok);

  assign din = '{bi: rx_bi, fe: rx_fe, pe: rx_pe, data: rx_dout};

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (din),
    .head  (head),
    .level (level)
  );

  assign rbr = dr ? head.data : 8'h00;
  assign pe  = dr & head.pe;
  assign fe  = dr & head.fe;
  assign bi  = dr & head.bi;

  // Remember the mode so a change flushes the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fifo_en_q <= 1'b0;
    else      fifo_en_q <= fifo_en;
  end

  // Sticky overrun; a new overrun wins over lsr_rd
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        oe <= 1'b0;
    else if (ovr)    oe <= 1'b1;
    else if (lsr_rd) oe <= 1'b0;
  end

  assign err_inc = push_ok & (rx_pe | rx_fe | rx_bi);
  assign err_dec = pop_ok & (head.pe | head.fe | head.bi);

  // Count of stored entries carrying any error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       err_cnt <= '0;
    else if (flush) err_cnt <= '0;
    else            err_cnt <= err_cnt + LW'(err_inc) - LW'(err_dec);
  end

  assign fifo_err = (err_cnt != '0);

  assign trig = LW'(trig_entries(trig_lvl_e'(trig_lvl), DEPTH));

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TO_TICKS);
  localparam logic [TW-1:0] TICK_MAX = TW'(TO_TICKS - 1);

  to_state_e     to_st;
  logic [TW-1:0] tk;

  // Character timeout: idle ticks while data waits in the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_st <= TO_IDLE;
      tk    <= '0;
    end else if (flush || !fifo_en || lvl_nxt == '0) begin
      to_st <= TO_IDLE;
      tk    <= '0;
    end else begin
      unique case (to_st)
        TO_IDLE: begin
          to_st <= TO_ARMED;
          tk    <= '0;
        end
        TO_ARMED: begin
          if (push_ok || pop_ok) begin
            tk <= '0;
          end else if (char_tick) begin
            if (tk == TICK_MAX) begin
              to_st <= TO_TIMEOUT;
              tk    <= '0;
            end else begin
              tk <= tk + 1'b1;
            end
          end
        end
        TO_TIMEOUT: begin
          if (pop_ok) begin
            to_st <= TO_ARMED;
            tk    <= '0;
          end
        end
        default: begin
          to_st <= TO_IDLE;
          tk    <= '0;
        end
      endcase
    end
  end

  assign to_int = (to_st == TO_TIMEOUT);
`else
  logic unused_tick;
  assign unused_tick = char_tick;
  assign to_int      = 1'b0;
`endif

  assign rx_int = (fifo_en ? (level >= trig) : dr) | to_int;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl.
// Queue-based reference model plus directed and random stimulus.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_push = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       rx_pe = 1'b0;
  logic       rx_fe = 1'b0;
  logic       rx_bi = 1'b0;
  logic       rbr_rd = 1'b0;
  logic       lsr_rd = 1'b0;
  logic       fifo_en = 1'b1;
  logic       fifo_clr = 1'b0;
  logic [1:0] trig_lvl = 2'b00;
  logic       char_tick = 1'b0;
  logic [7:0] rbr;
  logic       dr, oe, pe, fe, bi;
  logic       fifo_err, rx_int;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_push   (rx_push),
    .rx_dout   (rx_dout),
    .rx_pe     (rx_pe),
    .rx_fe     (rx_fe),
    .rx_bi     (rx_bi),
    .rbr_rd    (rbr_rd),
    .lsr_rd    (lsr_rd),
    .fifo_en   (fifo_en),
    .fifo_clr  (fifo_clr),
    .trig_lvl  (trig_lvl),
    .char_tick (char_tick),
    .rbr       (rbr),
    .dr        (dr),
    .oe        (oe),
    .pe        (pe),
    .fe        (fe),
    .bi        (bi),
    .fifo_err  (fifo_err),
    .rx_int    (rx_int),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: entries are {bi,fe,pe,data}
  logic [10:0] mq[$];
  bit m_oe = 0;
  bit m_en_prev = 0;
  int m_tk = 0;
  bit m_to = 0;

  always @(posedge clk or negedge rst) begin : model
    if (!rst) begin
      mq.delete();
      m_oe = 0;
      m_en_prev = 0;
      m_tk = 0;
      m_to = 0;
    end else begin
      bit fl, po, pu, ov;
      int eff;
      fl = fifo_clr || (fifo_en != m_en_prev);
      m_en_prev = fifo_en;
      eff = fifo_en ? DEPTH : 1;
      po = 0; pu = 0; ov = 0;
      if (fl) begin
        mq.delete();
      end else begin
        po = rbr_rd && mq.size() > 0;
        pu = rx_push && (mq.size() < eff || po);
        ov = rx_push && !pu;
        if (po) void'(mq.pop_front());
        if (pu) mq.push_back({rx_bi, rx_fe, rx_pe, rx_dout});
      end
      if (ov) m_oe = 1;
      else if (lsr_rd) m_oe = 0;
`ifdef UART_RX_TIMEOUT_EN
      if (fl || !fifo_en || mq.size() == 0) begin
        m_to = 0; m_tk = 0;
      end else if (m_to) begin
        if (po) begin m_to = 0; m_tk = 0; end
      end else if (pu || po) begin
        m_tk = 0;
      end else if (char_tick) begin
        m_tk++;
        if (m_tk == 4) begin m_to = 1; m_tk = 0; end
      end
`endif
    end
  end

  // Compare every cycle against the model
  always @(negedge clk) begin : cmp
    int n, nerr, tt;
    logic [10:0] h;
    n = mq.size();
    h = (n > 0) ? mq[0] : 11'h0;
    nerr = 0;
    foreach (mq[i]) if (mq[i][10:8] != 3'b000) nerr++;
    case (trig_lvl)
      2'd0: tt = 1;
      2'd1: tt = 4;
      2'd2: tt = 8;
      default: tt = 14;
    endcase
    if (tt > DEPTH) tt = DEPTH;
    chk("level", 32'(level), 32'(n));
    chk("dr", 32'(dr), 32'(n > 0));
    chk("oe", 32'(oe), 32'(m_oe));
    chk("rbr", 32'(rbr), 32'(h[7:0]));
    chk("pe", 32'(pe), 32'(h[8]));
    chk("fe", 32'(fe), 32'(h[9]));
    chk("bi", 32'(bi), 32'(h[10]));
    chk("fifo_err", 32'(fifo_err), 32'(nerr > 0));
    chk("rx_int", 32'(rx_int),
        32'((fifo_en ? (n >= tt) : (n > 0)) || m_to));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rx_push = 0; rbr_rd = 0; lsr_rd = 0;
    fifo_clr = 0; char_tick = 0;
    rx_pe = 0; rx_fe = 0; rx_bi = 0;
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] f);
    rx_push = 1; rx_dout = d;
    {rx_bi, rx_fe, rx_pe} = f;
    tick();
  endtask

  task automatic pop();
    rbr_rd = 1;
    tick();
  endtask

  task automatic flush();
    fifo_clr = 1; lsr_rd = 1;
    tick();
  endtask

  initial begin
    int pp, pr;
    repeat (3) tick();
    chk("rst_level", 32'(level), 0);
    chk("rst_dr", 32'(dr), 0);
    chk("rst_oe", 32'(oe), 0);
    chk("rst_rx_int", 32'(rx_int), 0);
    rst = 1;
    repeat (2) tick();

    // In-order delivery
    push(8'h41, 3'b000);
    push(8'h42, 3'b000);
    push(8'h43, 3'b000);
    chk("ord0", 32'(rbr), 32'h41);
    pop();
    chk("ord1", 32'(rbr), 32'h42);
    pop();
    chk("ord2", 32'(rbr), 32'h43);
    pop();
    chk("ord_dr", 32'(dr), 0);

    // Overrun on the 17th push
    for (int i = 0; i < 17; i++) push(8'(i), 3'b000);
    chk("full_level", 32'(level), 16);
    chk("full_oe", 32'(oe), 1);
    chk("full_head", 32'(rbr), 0);
    lsr_rd = 1;
    tick();
    chk("oe_clr", 32'(oe), 0);

    // Push and pop together when full
    rx_push = 1; rx_dout = 8'h55; rbr_rd = 1;
    tick();
    chk("pp_level", 32'(level), 16);
    chk("pp_oe", 32'(oe), 0);
    repeat (15) pop();
    chk("pp_16th", 32'(rbr), 32'h55);
    flush();

    // Error counter
    push(8'h10, 3'b010);
    push(8'h20, 3'b000);
    chk("err_set", 32'(fifo_err), 1);
    chk("err_fe", 32'(fe), 1);
    pop();
    chk("err_clr", 32'(fifo_err), 0);
    chk("err_fe0", 32'(fe), 0);
    chk("err_rbr", 32'(rbr), 32'h20);
    flush();

    // Timeout interrupt
    trig_lvl = 2'b01;
    push(8'h01, 3'b000);
    push(8'h02, 3'b000);
    repeat (3) begin char_tick = 1; tick(); end
    chk("to_early", 32'(rx_int), 0);
    char_tick = 1;
    tick();
`ifdef UART_RX_TIMEOUT_EN
    chk("to_fire", 32'(rx_int), 1);
`else
    chk("to_fire", 32'(rx_int), 0);
`endif
    pop();
    chk("to_pop", 32'(rx_int), 0);
    flush();
    trig_lvl = 2'b00;

    // Holding-register mode and async reset
    fifo_en = 0;
    repeat (2) tick();
    push(8'hAA, 3'b000);
    push(8'hBB, 3'b000);
    chk("hr_rbr", 32'(rbr), 32'hAA);
    chk("hr_oe", 32'(oe), 1);
    rst = 0;
    #1;
    chk("arst_dr", 32'(dr), 0);
    chk("arst_oe", 32'(oe), 0);
    #1;
    rst = 1;
    tick();
    fifo_en = 1;
    repeat (2) tick();

    // Randomized traffic
    pp = 50; pr = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        pp = $urandom_range(10, 90);
        pr = $urandom_range(5, 90);
      end
      if (c % 150 == 0) trig_lvl = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) fifo_en = ~fifo_en;
      rx_push   = ($urandom_range(0, 99) < pp);
      rx_dout   = 8'($urandom);
      rx_pe     = ($urandom_range(0, 99) < 8);
      rx_fe     = ($urandom_range(0, 99) < 8);
      rx_bi     = ($urandom_range(0, 99) < 5);
      rbr_rd    = ($urandom_range(0, 99) < pr);
      lsr_rd    = ($urandom_range(0, 99) < 10);
      fifo_clr  = ($urandom_range(0, 199) == 0);
      char_tick = ($urandom_range(0, 99) < 40);
      tick();
    end
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
